// File: rtl/divider_pkg.sv
// Shared constants and FSM state encoding for the sequential fixed-point divider.
package divider_pkg;

  localparam int WIDTH_DEF = 10;
  localparam int FRAC_DEF  = 5;
  localparam int N_DEF     = WIDTH_DEF + FRAC_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/divider_datapath.sv
// Restoring shift-subtract datapath: one quotient bit per step, result saturation and flags.
module divider_datapath import divider_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FRAC  = FRAC_DEF
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             last_step,
  output logic [WIDTH-1:0] q_out,
  output logic             dvz,
  output logic             ovf
);

  localparam int N  = WIDTH + FRAC;
  localparam int CW = $clog2(N);

  logic [WIDTH:0]   rem_q, rem_d;
  logic [N-1:0]     dvd_q, dvd_d;
  logic [N-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_out_q, q_out_d;
  logic             dvz_q, dvz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic             q_bit;
  logic [N-1:0]     quo_step;

  always_comb begin
    rem_shift = {rem_q[WIDTH-1:0], dvd_q[N-1]};
    rem_diff  = rem_shift - {1'b0, b_q};
    q_bit     = (rem_shift >= {1'b0, b_q});
    quo_step  = {quo_q[N-2:0], q_bit};
    last_step = (cnt_q == CW'(N - 1));

    rem_d   = rem_q;
    dvd_d   = dvd_q;
    quo_d   = quo_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    q_out_d = q_out_q;
    dvz_d   = dvz_q;
    ovf_d   = ovf_q;

    if (load) begin
      rem_d   = {(WIDTH+1){1'b0}};
      dvd_d   = {a_in, {FRAC{1'b0}}};
      quo_d   = {N{1'b0}};
      b_d     = b_in;
      cnt_d   = {CW{1'b0}};
      q_out_d = {WIDTH{1'b0}};
      dvz_d   = (b_in == {WIDTH{1'b0}});
      ovf_d   = 1'b0;
    end else if (step) begin
      rem_d = q_bit ? rem_diff : rem_shift;
      dvd_d = {dvd_q[N-2:0], 1'b0};
      quo_d = quo_step;
      cnt_d = cnt_q + 1'b1;
      // Any set bit above the output width means the quotient does not fit.
      if (last_step) begin
        if (|quo_step[N-1:WIDTH]) begin
          q_out_d = {WIDTH{1'b1}};
          ovf_d   = 1'b1;
        end else begin
          q_out_d = quo_step[WIDTH-1:0];
          ovf_d   = 1'b0;
        end
      end else begin
        q_out_d = q_out_q;
        ovf_d   = ovf_q;
      end
    end else begin
      rem_d = rem_q;
    end
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      rem_q   <= {(WIDTH+1){1'b0}};
      dvd_q   <= {N{1'b0}};
      quo_q   <= {N{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
      q_out_q <= {WIDTH{1'b0}};
      dvz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      quo_q   <= quo_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      q_out_q <= q_out_d;
      dvz_q   <= dvz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign q_out = q_out_q;
  assign dvz   = dvz_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/divider.sv
// Sequential unsigned fixed-point divider: start/busy/valid control FSM around the datapath.
module divider import divider_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FRAC  = FRAC_DEF
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] q_out,
  output logic             dvz,
  output logic             ovf,
  output logic             busy,
  output logic             valid
);

  state_e state_q, state_d;
  logic   busy_q, busy_d;
  logic   valid_q, valid_d;
  logic   load;
  logic   last_step;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        // A zero divisor needs no iterations: report it at the accept edge.
        if (start) begin
          load    = 1'b1;
          state_d = (b_in == {WIDTH{1'b0}}) ? DONE : RUN;
        end else begin
          state_d = state_q;
        end
      end
      RUN: begin
        if (last_step) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d == RUN);
    valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;

  divider_datapath #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_datapath (
    .clk       (clk),
    .sclr      (sclr),
    .load      (load),
    .step      (state_q == RUN),
    .a_in      (a_in),
    .b_in      (b_in),
    .last_step (last_step),
    .q_out     (q_out),
    .dvz       (dvz),
    .ovf       (ovf)
  );

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: stimulus pushes expected results, a monitor checks each new valid.
module tb_divider;

  typedef struct packed {
    logic [9:0] q;
    logic       dvz;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       sclr;
  logic       start;
  logic [9:0] a_in;
  logic [9:0] b_in;
  logic [9:0] q_out;
  logic       dvz;
  logic       ovf;
  logic       busy;
  logic       valid;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   passed = 0;
  logic valid_prev = 1'b0;

  always #5 clk = ~clk;

  divider #(.WIDTH(10), .FRAC(5)) dut (
    .clk   (clk),
    .sclr  (sclr),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .q_out (q_out),
    .dvz   (dvz),
    .ovf   (ovf),
    .busy  (busy),
    .valid (valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  function automatic exp_t mk(input logic [9:0] q, input logic d, input logic o);
    exp_t e;
    e.q = q; e.dvz = d; e.ovf = o;
    return e;
  endfunction

  function automatic exp_t model(input logic [9:0] a, input logic [9:0] b);
    logic [14:0] q;
    if (b == 10'd0) return mk(10'd0, 1'b1, 1'b0);
    q = {a, 5'b00000} / {5'b00000, b};
    if (q > 15'd1023) return mk(10'h3FF, 1'b0, 1'b1);
    return mk(q[9:0], 1'b0, 1'b0);
  endfunction

  // Monitor: every rising valid consumes one expected result.
  always @(negedge clk) begin
    if (valid && !valid_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_valid: got valid with q_out=%0h, expected no result", q_out);
      end else begin
        mon_e = exp_q.pop_front();
        check("q_out", 32'(q_out), 32'(mon_e.q));
        check("dvz", 32'(dvz), 32'(mon_e.dvz));
        check("ovf", 32'(ovf), 32'(mon_e.ovf));
      end
    end
    valid_prev = valid;
  end

  task automatic run_div(input logic [9:0] a, input logic [9:0] b, input exp_t e,
                         input int hold, input int exp_lat, input bit poke);
    int  k;
    int  busy_cnt;
    bit  got;
    @(negedge clk);
    a_in = a; b_in = b; start = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    busy_cnt = busy ? 1 : 0;
    got = valid;
    if (hold == 1) start = 1'b0;
    k = 0;
    while (!got && k < 40) begin
      @(posedge clk); k++; #1;
      if (k >= hold - 1) start = 1'b0;
      if (poke && k == 5) begin
        start = 1'b1; a_in = ~a; b_in = 10'd1;
      end
      if (poke && k == 6) start = 1'b0;
      if (valid) got = 1'b1;
      else if (busy) busy_cnt++;
    end
    start = 1'b0;
    if (!got) begin
      checks++;
      $display("FAIL valid_timeout: got no valid in 40 cycles, expected valid after %0d", exp_lat);
    end else begin
      check("latency", 32'(k), 32'(exp_lat));
    end
    check("busy_cycles", 32'(busy_cnt), 32'(exp_lat));
  endtask

  task automatic do_sclr();
    @(negedge clk);
    sclr = 1'b1;
    @(posedge clk); #1;
    sclr = 1'b0;
  endtask

  initial begin
    sclr = 1'b1; start = 1'b0; a_in = 10'd0; b_in = 10'd0;
    repeat (3) @(posedge clk);
    #1 sclr = 1'b0;
    check("reset_q_out", 32'(q_out), 32'd0);
    check("reset_dvz", 32'(dvz), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_valid", 32'(valid), 32'd0);

    // 22.5 / 5.25 with a two-cycle start pulse, then DONE must hold
    run_div(10'b1011010000, 10'b0010101000, mk(10'd137, 1'b0, 1'b0), 2, 15, 1'b0);
    repeat (4) @(negedge clk);
    check("done_hold_valid", 32'(valid), 32'd1);
    check("done_hold_q", 32'(q_out), 32'd137);
    do_sclr();
    check("sclr_q_out", 32'(q_out), 32'd0);
    check("sclr_valid", 32'(valid), 32'd0);
    check("sclr_busy", 32'(busy), 32'd0);

    // Divide by zero: DONE at the accept edge, busy never set
    run_div(10'b0000010000, 10'd0, mk(10'd0, 1'b1, 1'b0), 1, 0, 1'b0);
    // Overflow, started directly from DONE
    run_div(10'b1001010000, 10'b0000001000, mk(10'h3FF, 1'b0, 1'b1), 1, 15, 1'b0);

    // Abort mid-run with sclr
    @(negedge clk);
    a_in = 10'b1001010000; b_in = 10'b0010001000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    do_sclr();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_q_out", 32'(q_out), 32'd0);
    run_div(10'b1001010000, 10'b0010001000, mk(10'd139, 1'b0, 1'b0), 1, 15, 1'b0);

    // 2.5 / 12.25 with a stray start and changed inputs while busy
    run_div(10'b0001010000, 10'b0110001000, mk(10'd6, 1'b0, 1'b0), 1, 15, 1'b1);

    // Boundary: largest representable quotient, then first overflowing one
    run_div(10'd1023, 10'd32, mk(10'h3FF, 1'b0, 1'b0), 1, 15, 1'b0);
    run_div(10'd512, 10'd16, mk(10'h3FF, 1'b0, 1'b1), 1, 15, 1'b0);
    run_div(10'd1, 10'd1023, mk(10'd0, 1'b0, 1'b0), 1, 15, 1'b0);

    for (int i = 0; i < 8; i++) begin
      logic [9:0] ra;
      logic [9:0] rb;
      ra = 10'($urandom_range(0, 1023));
      rb = 10'($urandom_range(1, 1023));
      run_div(ra, rb, model(ra, rb), 1, 15, 1'b0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
